fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin write arbiter that shares one synchronous FIFO write port among NUM_REQ producers. Each producer presents a request with data. The arbiter grants one producer at a time for a burst of up to BURST_MAX beats, then rotates priority. It sits directly in front of the FIFO write side, drives the FIFO's write enable and data, and obeys the FIFO full flag.

## Interface
- NUM_REQ, 4: number of producers (2..8)
- DATA_WIDTH, 8: beat width, equal to the FIFO data width
- BURST_MAX, 4: maximum beats per grant (1..16)
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  reset: synchronous, active-low; clock clk
- req  in  NUM_REQ  per-producer request; bit i means producer i has a valid beat
- data_in  in  NUM_REQ*DATA_WIDTH  producer i's beat occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- last  in  NUM_REQ  producer i marks its current beat as the final beat of its burst
- fifo_full  in  1  full flag from the FIFO
- grant  out  NUM_REQ  one-hot (or zero) registered grant
- fifo_wr_en  out  1  FIFO write enable
- fifo_data  out  DATA_WIDTH  FIFO write data (the granted producer's slice)
- beat_ack  out  NUM_REQ  one-hot; bit i pulses in the cycle producer i's beat is written
- busy  out  1  high when state is BURST

## Operation
- States:
  - IDLE: grant = 0.
  - BURST: exactly one grant bit is set.
- Arbitration (IDLE, any req bit set):
  - Search starts at ptr+1 mod NUM_REQ, wraps around, and picks the first set bit.
  - That producer becomes the owner; grant is set next cycle; state goes to BURST; the beat counter clears to 0.
  - ptr is the index of the last owner. Reset value is NUM_REQ-1, so producer 0 has first priority after reset.
- A beat transfers when state is BURST, req[owner] = 1 and fifo_full = 0. On a transfer:
  - fifo_wr_en = 1
  - fifo_data = owner's data slice
  - beat_ack[owner] = 1
  - the beat counter increments
- These outputs are combinational from the registered state, grant, req and fifo_full:
  - fifo_wr_en, fifo_data, beat_ack
  - When fifo_wr_en is 0, fifo_data is 0.
- A burst ends, and the next state is IDLE with grant = 0 and ptr = owner, when any of these holds:
  - a transfer occurs with last[owner] = 1
  - a transfer occurs and it is beat number BURST_MAX (counter reaches BURST_MAX-1 before the increment)
  - req[owner] = 0 in a BURST cycle (owner abandons; no write that cycle)
- fifo_full = 1 in BURST:
  - no write, no ack, counter holds, grant holds
  - stalls do not count toward BURST_MAX
- Requests from non-owners are ignored during BURST. No data from a non-granted producer ever reaches the FIFO.
- last is ignored unless a transfer occurs in that cycle.
- Beat counter width: $clog2(BURST_MAX+1).

## Timing
- Reset (rst = 0 at a clock edge), outputs after that edge:
  - state = IDLE, grant = 0, ptr = NUM_REQ-1, counter = 0
  - fifo_wr_en = 0, fifo_data = 0, beat_ack = 0, busy = 0
- rst mid-burst aborts the burst at that edge. No write occurs in the reset cycle: fifo_wr_en is forced 0 while rst = 0.
- Latency: req seen in IDLE at edge N → grant and busy high after edge N → first beat can be written in cycle N+1.
- At the end of a burst, one IDLE bubble cycle always follows before any new grant. Minimum period between grants is BURST_MAX+1 cycles for an unstalled full-length burst.
- Back-to-back beats within a burst: one per cycle while req is held and the FIFO is not full.
- Producers must hold data_in and last stable while req is high and beat_ack is low.
- Fairness: with all producers continuously requesting, grants rotate 0,1,2,…,NUM_REQ-1,0,…

## Structure
- Shared package fifo_arb_pkg:
  - state typedef (IDLE, BURST)
  - default parameter constants
- Sub-module rr_pick: combinational round-robin priority picker.
  - Inputs: req, ptr.
  - Outputs: one-hot winner, binary winner index, valid.
  - Reused by other arbiters in this design.
- Top module contains the state register, grant, ptr, beat counter and output muxing.

## Test plan
- Reset then single requester: req = 4'b0100, bursts of 2 beats with last on beat 2.
  - grant = 4'b0100 one cycle after req.
  - Two writes on consecutive cycles.
  - grant = 0 for one cycle, then grant = 4'b0100 again.
- All four requesting continuously, last never asserted, BURST_MAX = 4:
  - grants 0,1,2,3,0 in order
  - each owner gets exactly 4 writes
  - a 1-cycle gap with grant = 0 between owners
- fifo_full asserted for 3 cycles mid-burst on beat 2:
  - no fifo_wr_en during the stall, grant held
  - the burst resumes and still totals 4 beats
- Owner drops req after 1 beat:
  - the burst ends with 1 write
  - the next edge gives grant = 0
  - the next requester in rotation is granted the following cycle
- rst = 0 asserted in the middle of a 4-beat burst:
  - the next cycle shows grant = 0, fifo_wr_en = 0, busy = 0
  - after reset release with req = 4'b1010, producer 1 is granted first
- Scoreboard over random req/last/fifo_full:
  - every FIFO write equals the granted producer's data
  - grant is always one-hot or zero
  - no write occurs while fifo_full = 1
  - no burst exceeds BURST_MAX beats

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and default constants for the FIFO write arbiter
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_BURST_MAX  = 4;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, search starts just after ptr
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  win_onehot,
    output logic [IW-1:0] win_idx,
    output logic          valid
);

    always_comb begin
        int j;
        win_onehot = '0;
        win_idx    = '0;
        valid      = 1'b0;
        j          = 0;
        // k = N revisits ptr itself, so a lone requester at ptr still wins
        for (int k = 1; k <= N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!valid && req[j]) begin
                valid         = 1'b1;
                win_idx       = IW'(j);
                win_onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BURST_MAX  = DEF_BURST_MAX
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
    input  logic [NUM_REQ-1:0]            last,
    input  logic                          fifo_full,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic [NUM_REQ-1:0]            beat_ack,
    output logic                          busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BURST_MAX + 1);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic               owner_req;
    logic               burst_done;

    rr_pick #(.N(NUM_REQ), .IW(IDX_W)) u_pick (
        .req        (req),
        .ptr        (ptr_q),
        .win_onehot (pick_onehot),
        .win_idx    (pick_idx),
        .valid      (pick_valid)
    );

    assign owner_req  = req[owner_q];
    assign burst_done = last[owner_q] || (cnt_q == CNT_W'(BURST_MAX - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_BURST;
                    grant_d = pick_onehot;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                end
            end
            ST_BURST: begin
                if (!owner_req) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = owner_q;
                end else if (!fifo_full) begin
                    cnt_d = cnt_q + 1'b1;
                    if (burst_done) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        ptr_d   = owner_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // rst gates the write so an aborted burst never leaks a beat in the reset cycle
    always_comb begin
        fifo_wr_en = rst && (state_q == ST_BURST) && owner_req && !fifo_full;
        fifo_data  = '0;
        beat_ack   = '0;
        if (fifo_wr_en) begin
            fifo_data = data_in[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
            beat_ack  = grant_q;
        end
        busy = (state_q == ST_BURST);
    end

    assign grant = grant_q;

endmodule
